// File: rtl/wfg_slot_sched_pkg.sv
// wfg_slot_sched_pkg
// Shared types and constants for the waveform-generator slot scheduler.
//   state_t     : scheduler FSM state (IDLE / WAIT_SYNC / RUN), 2-bit encoding
//   MISS_CNT_W  : width of the optional miss counter (WFG_SLOT_SCHED_STATS_EN)
package wfg_slot_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int MISS_CNT_W = 16;

endpackage

// File: rtl/wfg_slot_sched_if.sv
// wfg_slot_sched_if
// Bundles the core timing pulses, channel requests and grant outputs of the
// slot scheduler.
//   master : driven by the core / register side (core_*, chan_en_i, req_i)
//   slave  : the scheduler (consumes core_*, chan_en_i, req_i; drives grant_*,
//            slot_idx_o, busy_o, miss_o and, with WFG_SLOT_SCHED_STATS_EN
//            defined, miss_cnt_o)
// Parameters: NCH requesting channels, IDW grant id width.
interface wfg_slot_sched_if #(
    parameter int NCH = 4,
    parameter int IDW = 3
);
    import wfg_slot_sched_pkg::*;

    logic           core_active_i;
    logic           core_start_i;
    logic           core_sync_i;
    logic           core_subcycle_i;
    logic [7:0]     core_subcycle_cnt_i;
    logic [NCH-1:0] chan_en_i;
    logic [NCH-1:0] req_i;
    logic [NCH-1:0] grant_o;
    logic [IDW-1:0] grant_id_o;
    logic           grant_valid_o;
    logic [7:0]     slot_idx_o;
    logic           busy_o;
    logic           miss_o;
`ifdef WFG_SLOT_SCHED_STATS_EN
    logic [MISS_CNT_W-1:0] miss_cnt_o;
`endif

    modport master (
`ifdef WFG_SLOT_SCHED_STATS_EN
        input  miss_cnt_o,
`endif
        output core_active_i, core_start_i, core_sync_i, core_subcycle_i,
        output core_subcycle_cnt_i, chan_en_i, req_i,
        input  grant_o, grant_id_o, grant_valid_o, slot_idx_o, busy_o, miss_o
    );

    modport slave (
`ifdef WFG_SLOT_SCHED_STATS_EN
        output miss_cnt_o,
`endif
        input  core_active_i, core_start_i, core_sync_i, core_subcycle_i,
        input  core_subcycle_cnt_i, chan_en_i, req_i,
        output grant_o, grant_id_o, grant_valid_o, slot_idx_o, busy_o, miss_o
    );

endinterface

// File: rtl/wfg_rr_pick.sv
// wfg_rr_pick
// Combinational rotate-priority picker: starting at ptr and wrapping modulo
// NCH, returns the first set bit of elig.
//   elig  : eligible channel vector
//   ptr   : starting channel (must be < NCH)
//   found : at least one eligible channel
//   idx   : index of the selected channel (0 when found is low)
module wfg_rr_pick #(
    parameter int NCH = 4,
    parameter int IDW = 3
) (
    input  logic [NCH-1:0] elig,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    // Pad elig to the full index range so every IDW-bit index is in bounds.
    logic [(2**IDW)-1:0] elig_pad;
    logic [IDW-1:0]      cand [NCH];
    logic [NCH-1:0]      hit;

    assign elig_pad = (2**IDW)'(elig);

    // cand[gi] is the channel at priority position gi, wrapped modulo NCH
    // (not 2**IDW) so non-power-of-two channel counts rotate correctly.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
        logic [IDW:0] sum;
        assign sum       = {1'b0, ptr} + (IDW+1)'(gi);
        assign cand[gi]  = (sum >= (IDW+1)'(NCH)) ? IDW'(sum - (IDW+1)'(NCH))
                                                  : sum[IDW-1:0];
        assign hit[gi]   = elig_pad[cand[gi]];
    end

    // Lowest priority position wins: scan from the back so earlier hits override.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found = 1'b1;
                idx   = cand[i];
            end
        end
    end

endmodule

// File: rtl/wfg_slot_sched.sv
// wfg_slot_sched
// Round-robin slot scheduler driven by the waveform-generator timing core.
// Each subcycle pulse in RUN grants one slot to the next eligible channel;
// a sync pulse reloads the channel-enable shadow and restarts priority at 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wfg_slot_sched_if.slave (core pulses, chan_en_i, req_i in;
//                grant_o, grant_id_o, grant_valid_o, slot_idx_o, busy_o,
//                miss_o out)
// Optional: define WFG_SLOT_SCHED_STATS_EN to add miss_cnt_o, a saturating
// count of miss pulses cleared on reset and on entry to WAIT_SYNC.
import wfg_slot_sched_pkg::*;

module wfg_slot_sched #(
    parameter int NCH = 4,
    parameter int IDW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    wfg_slot_sched_if.slave bus
);

    state_t         state_reg, state_next;
    logic [NCH-1:0] mask_reg, mask_next;
    logic [IDW-1:0] ptr_reg, ptr_next;
    logic [NCH-1:0] grant_reg, grant_next;
    logic [IDW-1:0] id_reg, id_next;
    logic           valid_reg, valid_next;
    logic [7:0]     slot_reg, slot_next;
    logic           miss_reg, miss_next;
    logic           busy;

    logic           run_sync;
    logic [NCH-1:0] arb_mask;
    logic [NCH-1:0] elig;
    logic [IDW-1:0] arb_ptr;
    logic           found;
    logic [IDW-1:0] win;

    // A sync in RUN takes effect before arbitration of the same cycle.
    assign run_sync = (state_reg == RUN) && bus.core_sync_i;
    assign arb_mask = run_sync ? bus.chan_en_i : mask_reg;
    assign arb_ptr  = run_sync ? '0 : ptr_reg;
    assign elig     = bus.req_i & arb_mask;

    wfg_rr_pick #(.NCH(NCH), .IDW(IDW)) u_pick (
        .elig  (elig),
        .ptr   (arb_ptr),
        .found (found),
        .idx   (win)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        if (!bus.core_active_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:      if (bus.core_start_i) state_next = WAIT_SYNC;
                WAIT_SYNC: if (bus.core_sync_i)  state_next = RUN;
                RUN:       state_next = RUN;
                default:   state_next = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy = (state_reg == RUN);
    end

    // Datapath next values: mask shadow, pointer, grant registers, miss pulse.
    always_comb begin
        mask_next  = mask_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        id_next    = id_reg;
        valid_next = valid_reg;
        slot_next  = slot_reg;
        miss_next  = 1'b0;
        if (!bus.core_active_i) begin
            grant_next = '0;
            valid_next = 1'b0;
        end else if (state_reg == WAIT_SYNC && bus.core_sync_i) begin
            mask_next = bus.chan_en_i;
            ptr_next  = '0;
        end else if (state_reg == RUN) begin
            if (bus.core_sync_i) begin
                mask_next = bus.chan_en_i;
                ptr_next  = '0;
            end
            if (bus.core_subcycle_i) begin
                if (found) begin
                    grant_next      = '0;
                    grant_next[win] = 1'b1;
                    id_next         = win;
                    valid_next      = 1'b1;
                    slot_next       = bus.core_subcycle_cnt_i;
                    ptr_next        = (win == IDW'(NCH - 1)) ? '0 : win + 1'b1;
                end else begin
                    grant_next = '0;
                    valid_next = 1'b0;
                    miss_next  = 1'b1;
                end
            end else if (bus.core_sync_i) begin
                grant_next = '0;
                valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg  <= '0;
            ptr_reg   <= '0;
            grant_reg <= '0;
            id_reg    <= '0;
            valid_reg <= 1'b0;
            slot_reg  <= '0;
            miss_reg  <= 1'b0;
        end else begin
            mask_reg  <= mask_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            id_reg    <= id_next;
            valid_reg <= valid_next;
            slot_reg  <= slot_next;
            miss_reg  <= miss_next;
        end
    end

    assign bus.grant_o       = grant_reg;
    assign bus.grant_id_o    = id_reg;
    assign bus.grant_valid_o = valid_reg;
    assign bus.slot_idx_o    = slot_reg;
    assign bus.busy_o        = busy;
    assign bus.miss_o        = miss_reg;

`ifdef WFG_SLOT_SCHED_STATS_EN
    logic [MISS_CNT_W-1:0] miss_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_reg <= '0;
        end else if (state_reg == IDLE && state_next == WAIT_SYNC) begin
            miss_cnt_reg <= '0;
        end else if (miss_next && (miss_cnt_reg != '1)) begin
            miss_cnt_reg <= miss_cnt_reg + 1'b1;
        end
    end

    assign bus.miss_cnt_o = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_wfg_slot_sched.sv
module tb_wfg_slot_sched;
    localparam int NCH = 4;
    localparam int IDW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    wfg_slot_sched_if #(.NCH(NCH), .IDW(IDW)) bus ();

    wfg_slot_sched #(.NCH(NCH), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: 0=idle, 1=waiting for sync, 2=running
    int m_state, m_mask, m_ptr, m_gv, m_id, m_slot, m_miss, m_mcnt;

    function automatic int pick(input int elig, input int p);
        for (int o = 0; o < NCH; o++) begin
            int c;
            c = (p + o) % NCH;
            if ((elig >> c) & 1) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_mask = 0; m_ptr = 0; m_gv = 0;
        m_id = 0; m_slot = 0; m_miss = 0; m_mcnt = 0;
    endtask

    task automatic model_clock(input bit act, st, sy, sb, input int en, rq, cnt);
        int w;
        m_miss = 0;
        if (!act) begin
            m_state = 0;
            m_gv = 0;
        end else begin
            case (m_state)
                0: if (st) begin m_state = 1; m_mcnt = 0; end
                1: if (sy) begin m_state = 2; m_mask = en; m_ptr = 0; end
                default: begin
                    if (sy) begin m_mask = en; m_ptr = 0; end
                    if (sb) begin
                        w = pick(rq & m_mask, m_ptr);
                        if (w >= 0) begin
                            m_gv = 1; m_id = w; m_slot = cnt; m_ptr = (w + 1) % NCH;
                        end else begin
                            m_gv = 0; m_miss = 1;
                            if (m_mcnt < 65535) m_mcnt++;
                        end
                    end else if (sy) begin
                        m_gv = 0;
                    end
                end
            endcase
        end
    endtask

    // One clock of stimulus; the model advances with the same inputs.
    task automatic step(input bit act, st, sy, sb, input logic [3:0] en, rq);
        int cnt;
        cnt = int'($urandom_range(0, 255));
        @(negedge clk);
        bus.core_active_i       = act;
        bus.core_start_i        = st;
        bus.core_sync_i         = sy;
        bus.core_subcycle_i     = sb;
        bus.core_subcycle_cnt_i = 8'(cnt);
        bus.chan_en_i           = en;
        bus.req_i               = rq;
        @(posedge clk);
        model_clock(act, st, sy, sb, int'(en), int'(rq), cnt);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.core_active_i = 0; bus.core_start_i = 0; bus.core_sync_i = 0;
        bus.core_subcycle_i = 0; bus.core_subcycle_cnt_i = 0;
        bus.chan_en_i = 0; bus.req_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.grant_o !== 4'b0 || bus.grant_valid_o !== 1'b0 || bus.grant_id_o !== 3'b0) begin
            n_errors++;
            $display("FAIL reset_grant: got grant=%b valid=%b id=%0d, want 0", bus.grant_o, bus.grant_valid_o, bus.grant_id_o);
        end
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.miss_o !== 1'b0 || bus.slot_idx_o !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_status: got busy=%b miss=%b slot=%0d, want 0", bus.busy_o, bus.miss_o, bus.slot_idx_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_start_sync();
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        step(1, 1, 0, 0, 4'b1111, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 1, 4'b1111, 4'b1111);
            n_checks++;
            if (bus.grant_valid_o !== 1'b0 || bus.miss_o !== 1'b0) begin
                n_errors++;
                $display("FAIL pre_sync_subcycle: got valid=%b miss=%b, want 0 0", bus.grant_valid_o, bus.miss_o);
            end
        end
        step(1, 0, 1, 0, 4'b1111, 4'b1111);
        n_checks++;
        if (bus.busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_after_sync: got %b, want 1", bus.busy_o);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, 4'b1111, 4'b1111);
            n_checks++;
            if (bus.grant_valid_o !== 1'b1 || int'(bus.grant_id_o) != exp_ids[i]
                || bus.slot_idx_o !== 8'(m_slot)) begin
                n_errors++;
                $display("FAIL rr_grant[%0d]: got valid=%b id=%0d slot=%0d, want 1 %0d %0d",
                         i, bus.grant_valid_o, bus.grant_id_o, bus.slot_idx_o, exp_ids[i], m_slot);
            end
            // Request withdrawn mid-slot: grant is held.
            step(1, 0, 0, 0, 4'b1111, 4'b0000);
            n_checks++;
            if (bus.grant_o !== 4'(1 << exp_ids[i])) begin
                n_errors++;
                $display("FAIL grant_hold[%0d]: got %b, want %b", i, bus.grant_o, 4'(1 << exp_ids[i]));
            end
            $display("start_sync: slot %0d granted id %0d", i, bus.grant_id_o);
        end
    endtask

    task automatic test_mask_shadow();
        int exp_a[4] = '{1, 2, 3, 0};
        int exp_b[4] = '{0, 2, 0, 2};
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 4'b0101, 4'b1111);
            n_checks++;
            if (int'(bus.grant_id_o) != exp_a[i] || bus.grant_valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL shadow_old_mask[%0d]: got id=%0d valid=%b, want %0d 1", i, bus.grant_id_o, bus.grant_valid_o, exp_a[i]);
            end
        end
        step(1, 0, 1, 0, 4'b0101, 4'b1111);
        n_checks++;
        if (bus.grant_valid_o !== 1'b0 || bus.grant_o !== 4'b0) begin
            n_errors++;
            $display("FAIL sync_clears_grant: got valid=%b grant=%b, want 0", bus.grant_valid_o, bus.grant_o);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 4'b1111, 4'b1111);
            n_checks++;
            if (int'(bus.grant_id_o) != exp_b[i] || bus.grant_valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL shadow_new_mask[%0d]: got id=%0d valid=%b, want %0d 1", i, bus.grant_id_o, bus.grant_valid_o, exp_b[i]);
            end
        end
        $display("mask_shadow: old and new mask sequences checked");
    endtask

    task automatic test_miss();
        int misses = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 4'b1111, 4'b0000);
            if (bus.miss_o === 1'b1) misses++;
            n_checks++;
            if (bus.grant_valid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL miss_valid[%0d]: got %b, want 0", i, bus.grant_valid_o);
            end
            step(1, 0, 0, 0, 4'b1111, 4'b0000);
            if (bus.miss_o === 1'b1) misses++;
        end
        n_checks++;
        if (misses != 3) begin
            n_errors++;
            $display("FAIL miss_pulses: got %0d, want 3", misses);
        end
`ifdef WFG_SLOT_SCHED_STATS_EN
        n_checks++;
        if (bus.miss_cnt_o !== 16'd3) begin
            n_errors++;
            $display("FAIL miss_cnt: got %0d, want 3", bus.miss_cnt_o);
        end
`endif
        $display("miss: %0d miss pulses seen", misses);
    endtask

    task automatic test_sync_subcycle();
        step(1, 0, 1, 0, 4'b1111, 4'b1111);
        step(1, 0, 0, 1, 4'b1111, 4'b1111);
        step(1, 0, 0, 1, 4'b1111, 4'b1111);   // ptr now 2
        step(1, 0, 1, 1, 4'b1111, 4'b1111);
        n_checks++;
        if (bus.grant_id_o !== 3'd0 || bus.grant_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL sync_with_subcycle: got id=%0d valid=%b, want 0 1", bus.grant_id_o, bus.grant_valid_o);
        end
        $display("sync_subcycle: grant id %0d", bus.grant_id_o);
    endtask

    task automatic test_disable();
        step(1, 0, 0, 1, 4'b1111, 4'b1111);
        n_checks++;
        if (bus.grant_o !== 4'b0010) begin
            n_errors++;
            $display("FAIL disable_setup: got grant=%b, want 0010", bus.grant_o);
        end
        step(0, 0, 0, 1, 4'b1111, 4'b1111);
        n_checks++;
        if (bus.grant_o !== 4'b0 || bus.busy_o !== 1'b0 || bus.grant_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL disable_clear: got grant=%b busy=%b valid=%b, want 0 0 0", bus.grant_o, bus.busy_o, bus.grant_valid_o);
        end
        step(1, 0, 1, 0, 4'b1111, 4'b1111);
        step(1, 0, 0, 1, 4'b1111, 4'b1111);
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.grant_valid_o !== 1'b0 || bus.miss_o !== 1'b0) begin
            n_errors++;
            $display("FAIL sync_from_idle: got busy=%b valid=%b miss=%b, want 0 0 0", bus.busy_o, bus.grant_valid_o, bus.miss_o);
        end
        $display("disable: grant dropped, sync alone stays idle");
    endtask

    task automatic test_random();
        step(1, 1, 0, 0, 4'b1111, 4'b1111);
        step(1, 0, 1, 0, 4'b1111, 4'b1111);
        for (int i = 0; i < 400; i++) begin
            bit act, st, sy, sb;
            logic [3:0] exp_grant;
            act = ($urandom_range(0, 49) != 0);
            st  = ($urandom_range(0, 9) == 0);
            sy  = ($urandom_range(0, 7) == 0);
            sb  = ($urandom_range(0, 2) == 0);
            step(act, st, sy, sb, 4'($urandom), 4'($urandom));
            exp_grant = m_gv ? 4'(1 << m_id) : 4'b0;
            n_checks++;
            if (bus.grant_o !== exp_grant || bus.grant_valid_o !== 1'(m_gv)
                || bus.miss_o !== 1'(m_miss) || bus.busy_o !== (m_state == 2)) begin
                n_errors++;
                $display("FAIL random[%0d]: got grant=%b valid=%b miss=%b busy=%b, want %b %0d %0d %0d",
                         i, bus.grant_o, bus.grant_valid_o, bus.miss_o, bus.busy_o,
                         exp_grant, m_gv, m_miss, m_state == 2);
            end
            if (m_gv != 0) begin
                n_checks++;
                if (int'(bus.grant_id_o) != m_id || int'(bus.slot_idx_o) != m_slot) begin
                    n_errors++;
                    $display("FAIL random_id[%0d]: got id=%0d slot=%0d, want %0d %0d",
                             i, bus.grant_id_o, bus.slot_idx_o, m_id, m_slot);
                end
            end
`ifdef WFG_SLOT_SCHED_STATS_EN
            n_checks++;
            if (int'(bus.miss_cnt_o) != m_mcnt) begin
                n_errors++;
                $display("FAIL random_miss_cnt[%0d]: got %0d, want %0d", i, bus.miss_cnt_o, m_mcnt);
            end
`endif
            $display("random[%0d]: act=%b sync=%b sub=%b grant=%b miss=%b", i, act, sy, sb, bus.grant_o, bus.miss_o);
        end
    endtask

    task automatic test_async_reset();
        step(1, 1, 0, 0, 4'b1111, 4'b1111);
        step(1, 0, 1, 0, 4'b1111, 4'b1111);
        step(1, 0, 0, 1, 4'b1111, 4'b1111);
        n_checks++;
        if (bus.grant_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL async_setup: got valid=%b, want 1", bus.grant_valid_o);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.grant_o !== 4'b0 || bus.grant_valid_o !== 1'b0 || bus.busy_o !== 1'b0
            || bus.miss_o !== 1'b0 || bus.slot_idx_o !== 8'd0 || bus.grant_id_o !== 3'd0) begin
            n_errors++;
            $display("FAIL async_reset: got grant=%b valid=%b busy=%b miss=%b slot=%0d id=%0d, want all 0",
                     bus.grant_o, bus.grant_valid_o, bus.busy_o, bus.miss_o, bus.slot_idx_o, bus.grant_id_o);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        $display("async_reset: outputs cleared between edges");
    endtask

    initial begin
        test_reset();
        test_start_sync();
        test_mask_shadow();
        test_miss();
        test_sync_subcycle();
        test_disable();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wfg_slot_sched.md
Name: wfg_slot_sched

Overview:
Round-robin slot scheduler driven by the waveform-generator timing core.
- Consumes the core's start, sync and subcycle pulses.
- On every subcycle pulse, grants one subcycle time slot to one of NCH requesting output-driver channels.
- A sync pulse starts a new frame: the channel enable mask reloads and arbitration priority restarts at channel 0.
- Sits between wfg_core and the per-channel drivers.

Parameters:
- NCH, 4, number of requesting channels (2..8)
- IDW, 3, width of grant_id_o; must satisfy 2**IDW >= NCH

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- core_active_i  in  1  core enable/active indication
- core_start_i  in  1  one-cycle start pulse from core
- core_sync_i  in  1  one-cycle sync pulse from core
- core_subcycle_i  in  1  one-cycle subcycle pulse from core
- core_subcycle_cnt_i  in  8  core subcycle pulse counter
- chan_en_i  in  NCH  channel enable mask (register interface; shadowed)
- req_i  in  NCH  per-channel slot request (level)
- grant_o  out  NCH  one-hot grant, held for the whole slot
- grant_id_o  out  IDW  index of the granted channel
- grant_valid_o  out  1  a slot is currently granted
- slot_idx_o  out  8  core_subcycle_cnt_i captured at grant
- busy_o  out  1  high in state RUN
- miss_o  out  1  one-cycle pulse: subcycle occurred in RUN with no eligible requester

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs 0. State IDLE, RR pointer 0, mask shadow 0.
- States:
  - IDLE -> WAIT_SYNC on core_start_i & core_active_i.
  - WAIT_SYNC -> RUN on core_sync_i. On this transition, mask_shadow <= chan_en_i.
  - Any state -> IDLE when core_active_i == 0, synchronously in the next cycle. Grants clear in that same update.
- In WAIT_SYNC and IDLE, subcycle pulses are ignored; no grants and no miss pulses.
- Eligible channels: elig = req_i & mask_shadow, sampled in the pulse cycle.
- Arbitration happens only in RUN, on a core_subcycle_i cycle:
  - Search upward from ptr, wrapping modulo NCH, for the first set bit of elig.
  - Winner k: grant_o <= 1<<k, grant_id_o <= k, grant_valid_o <= 1, slot_idx_o <= core_subcycle_cnt_i, ptr <= (k+1) mod NCH.
  - No eligible channel: grant_o <= 0, grant_valid_o <= 0, miss_o pulses, ptr unchanged.
- Latency: grant outputs update 1 clk after the subcycle pulse (registered).
- Grant hold: grant is held until the next subcycle pulse, a sync pulse, or leaving RUN. Deasserting req_i mid-slot does not revoke the grant.
- Sync in RUN, applied before arbitration of the same cycle:
  - mask_shadow <= chan_en_i; ptr <= 0.
  - Sync without subcycle: grants cleared.
  - Sync coincident with subcycle: arbitration uses the new mask and ptr=0.
- chan_en_i changes between syncs have no effect until the next sync.
- core_start_i while already in RUN or WAIT_SYNC: ignored.
- ptr width IDW; wrap is explicit modulo NCH (not 2**IDW) when NCH is not a power of two.

Optional Feature:
Macro WFG_SLOT_SCHED_STATS_EN.
- Defined:
  - Adds output miss_cnt_o[15:0]: saturating count of miss_o pulses.
  - Cleared on reset and on entry to WAIT_SYNC.
  - Holds at 16'hFFFF once reached.
- Not defined: port and counter absent; all other behaviour identical.

Decomposition:
- Package wfg_slot_sched_pkg holds:
  - state enum typedef {IDLE, WAIT_SYNC, RUN} (2-bit)
  - localparam for the miss counter width (16)
- Natural sub-module: wfg_rr_pick, a combinational NCH-wide rotate-priority picker. Inputs elig and ptr; outputs found and idx. Instantiated once.

Test Plan:
- Start/sync entry:
  - Stimulus: start with core_active_i=1, subcycle pulses before sync, then sync with chan_en_i=4'b1111 and req_i=4'b1111.
  - Required: no grants before sync; busy_o=1 after sync.
  - Required: successive subcycles grant ids 0,1,2,3,0.
- Mask shadowing:
  - Stimulus: RUN with mask 4'b1111; change chan_en_i to 4'b0101 mid-frame.
  - Required: grants continue over all 4 channels until the next sync, then alternate 0,2.
- Miss:
  - Stimulus: RUN, req_i=0, 3 subcycle pulses.
  - Required: miss_o pulses 3 times; grant_valid_o=0; with the macro defined, miss_cnt_o=3.
- Simultaneous sync+subcycle:
  - Stimulus: ptr=2, req_i=4'b1111, sync and subcycle in the same cycle.
  - Required: grant_id_o=0 one clk later.
- Disable mid-grant:
  - Stimulus: core_active_i dropped while channel 1 holds a grant.
  - Required: next cycle grant_o=0, busy_o=0, state IDLE.
  - Required: a subsequent sync alone does not re-enter RUN.
- Async reset mid-operation:
  - Stimulus: rst_n asserted mid-slot.
  - Required: all outputs 0 immediately, without waiting for a clk edge.
